// File: rtl/cnt_slot_sched_pkg.sv
// Shared types and default sizing for the round-robin slot scheduler.
package cnt_slot_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  localparam int NREQ_DEF  = 4;
  localparam int CW_DEF    = 8;
  localparam int LIMIT_DEF = 10;

endpackage

// File: rtl/slot_counter.sv
// Modulo slot counter: counts 0..LIMIT while enabled, held at zero otherwise.
module slot_counter
  import cnt_slot_sched_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int LIMIT = LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] out
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (en && !clr && (count_q != CW'(LIMIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: rtl/cnt_slot_sched.sv
// Round-robin scheduler granting one shared slot counter to NREQ requesters,
// with one idle bubble cycle (flagged by slot_end) between consecutive slots.
module cnt_slot_sched
  import cnt_slot_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CW    = CW_DEF,
  parameter int LIMIT = LIMIT_DEF,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy,
  output logic [CW-1:0]   out,
  output logic            slot_end
);

  sched_state_t    state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gnt_id_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic            busy_q;
  logic            slot_end_q;

  logic            winner_found;
  logic [IW-1:0]   winner_id;
  logic [IW:0]     search_sum;
  logic [IW-1:0]   search_idx;
  logic            slot_done;
  logic [CW-1:0]   count;

  // Search upward from ptr_q; the extra sum bit keeps ptr+i below 2*NREQ so one
  // conditional subtract gives the modulo even when NREQ is not a power of two.
  always_comb begin
    winner_found = 1'b0;
    winner_id    = '0;
    search_sum   = '0;
    search_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      search_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (search_sum >= (IW+1)'(NREQ)) begin
        search_sum = search_sum - (IW+1)'(NREQ);
      end
      search_idx = search_sum[IW-1:0];
      if (!winner_found && req[search_idx]) begin
        winner_found = 1'b1;
        winner_id    = search_idx;
      end
    end
  end

  always_comb begin
    slot_done = (state_q == ST_RUN) &&
                ((count == CW'(LIMIT)) || !req[gnt_id_q]);
    ptr_d     = (gnt_id_q == IW'(NREQ - 1)) ? '0 : gnt_id_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      slot_end_q <= 1'b0;
    end else begin
      slot_end_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (winner_found) begin
            state_q  <= ST_RUN;
            gnt_q    <= NREQ'(1) << winner_id;
            gnt_id_q <= winner_id;
            busy_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (slot_done) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            slot_end_q <= 1'b1;
            ptr_q      <= ptr_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A terminal count and a dropped request in the same cycle are one slot end,
  // so the counter only needs the combined slot_done as its clear.
  slot_counter #(
    .CW    (CW),
    .LIMIT (LIMIT)
  ) u_slot_counter (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_RUN),
    .clr (slot_done),
    .out (count)
  );

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign out      = count;
  assign slot_end = slot_end_q;

endmodule

// File: tb/tb_cnt_slot_sched.sv
// Directed bench for cnt_slot_sched: default 4-requester instance plus a
// 3-requester instance for the non-power-of-two pointer wrap.
module tb_cnt_slot_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [7:0] out;
  logic       slot_end;

  logic       rst3;
  logic [2:0] req3;
  logic [2:0] gnt3;
  logic [1:0] gnt_id3;
  logic       busy3;
  logic [7:0] out3;
  logic       slot_end3;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  cnt_slot_sched #(.NREQ(4), .CW(8), .LIMIT(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .out      (out),
    .slot_end (slot_end)
  );

  cnt_slot_sched #(.NREQ(3), .CW(8), .LIMIT(10)) dut3 (
    .clk      (clk),
    .rst      (rst3),
    .req      (req3),
    .gnt      (gnt3),
    .gnt_id   (gnt_id3),
    .busy     (busy3),
    .out      (out3),
    .slot_end (slot_end3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] eGnt,
                          input logic [1:0] eId, input logic eBusy,
                          input logic [7:0] eOut, input logic eEnd);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(eGnt));
    if (eBusy) checkOutput({tag, ".gnt_id"}, 32'(gnt_id), 32'(eId));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(eBusy));
    checkOutput({tag, ".out"}, 32'(out), 32'(eOut));
    checkOutput({tag, ".slot_end"}, 32'(slot_end), 32'(eEnd));
  endtask

  initial begin
    logic [1:0] seq4 [5];
    logic [1:0] seq3 [3];
    seq4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    seq3 = '{2'd0, 2'd2, 2'd0};

    rst3 = 1'b1;
    req3 = 3'b000;
    applyStimulus(1'b1, 4'b0000);
    tick();
    tick();
    checkOutput("reset.gnt_id", 32'(gnt_id), 32'd0);
    checkAll("reset", 4'b0000, 2'd0, 1'b0, 8'd0, 1'b0);

    // Idle with no requests stays idle.
    applyStimulus(1'b0, 4'b0000);
    tick();
    checkAll("idle", 4'b0000, 2'd0, 1'b0, 8'd0, 1'b0);

    // Single requester: 11-cycle slot, bubble, re-grant 12 cycles later.
    applyStimulus(1'b0, 4'b0010);
    tick();
    for (int k = 0; k <= 10; k++) begin
      checkAll("single.run", 4'b0010, 2'd1, 1'b1, 8'(k), 1'b0);
      tick();
    end
    checkAll("single.bubble", 4'b0000, 2'd1, 1'b0, 8'd0, 1'b1);
    tick();
    checkAll("single.regrant", 4'b0010, 2'd1, 1'b1, 8'd0, 1'b0);

    // Minimum slot: release in the first RUN cycle.
    applyStimulus(1'b0, 4'b0000);
    tick();
    checkAll("minslot.end", 4'b0000, 2'd1, 1'b0, 8'd0, 1'b1);
    tick();
    checkAll("minslot.after", 4'b0000, 2'd1, 1'b0, 8'd0, 1'b0);

    // Full contention from reset.
    applyStimulus(1'b1, 4'b1111);
    tick();
    applyStimulus(1'b0, 4'b1111);
    tick();
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k <= 10; k++) begin
        checkAll("contend.run", 4'(4'b0001 << seq4[s]), seq4[s], 1'b1, 8'(k), 1'b0);
        tick();
      end
      checkAll("contend.bubble", 4'b0000, seq4[s], 1'b0, 8'd0, 1'b1);
      tick();
    end
    checkAll("contend.next", 4'b0010, 2'd1, 1'b1, 8'd0, 1'b0);

    // Requester 1 releases; requester 2 gets the next slot and releases at out==3.
    applyStimulus(1'b0, 4'b0100);
    tick();
    checkAll("early.bubble1", 4'b0000, 2'd1, 1'b0, 8'd0, 1'b1);
    tick();
    checkAll("early.grant2", 4'b0100, 2'd2, 1'b1, 8'd0, 1'b0);
    tick();
    tick();
    tick();
    checkAll("early.out3", 4'b0100, 2'd2, 1'b1, 8'd3, 1'b0);
    applyStimulus(1'b0, 4'b1001);
    tick();
    checkAll("early.end", 4'b0000, 2'd2, 1'b0, 8'd0, 1'b1);
    tick();
    checkAll("early.grant3", 4'b1000, 2'd3, 1'b1, 8'd0, 1'b0);

    // Grantee drops req exactly at the terminal count: one pulse, ptr 3 -> 0.
    for (int k = 0; k < 10; k++) tick();
    checkAll("simul.out10", 4'b1000, 2'd3, 1'b1, 8'd10, 1'b0);
    applyStimulus(1'b0, 4'b0011);
    tick();
    checkAll("simul.end", 4'b0000, 2'd3, 1'b0, 8'd0, 1'b1);
    tick();
    checkAll("simul.grant0", 4'b0001, 2'd0, 1'b1, 8'd0, 1'b0);

    // Reset mid-slot at out==5.
    for (int k = 0; k < 5; k++) tick();
    checkAll("rstmid.out5", 4'b0001, 2'd0, 1'b1, 8'd5, 1'b0);
    applyStimulus(1'b1, 4'b1100);
    tick();
    checkOutput("rstmid.gnt_id", 32'(gnt_id), 32'd0);
    checkAll("rstmid.reset", 4'b0000, 2'd0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 4'b1100);
    tick();
    checkAll("rstmid.grant2", 4'b0100, 2'd2, 1'b1, 8'd0, 1'b0);

    // NREQ=3 pointer wrap: grants alternate 0, 2, 0.
    applyStimulus(1'b1, 4'b0000);
    req3 = 3'b101;
    tick();
    rst3 = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      checkOutput("wrap3.gnt_id", 32'(gnt_id3), 32'(seq3[s]));
      checkOutput("wrap3.gnt", 32'(gnt3), 32'(3'b001 << seq3[s]));
      for (int k = 0; k < 10; k++) tick();
      checkOutput("wrap3.out10", 32'(out3), 32'd10);
      checkOutput("wrap3.gnt_id10", 32'(gnt_id3), 32'(seq3[s]));
      tick();
      checkOutput("wrap3.bubble", 32'(slot_end3), 32'd1);
      checkOutput("wrap3.bubble_gnt", 32'(gnt3), 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
